// File: rtl/noc_flit_unpacker.sv
// Parses header+payload packets from a first-word-fall-through FIFO; forwards packets for NODE_ID, drops and counts the rest.
// Latency: a payload word popped in cycle N is presented at N+1; pkt_done/pkt_err/drop_cnt update on the edge of the completing pop.
// Backpressure: an unaccepted full output register stalls payload pops. Define UNPACK_CHECKSUM_EN for the trailing XOR check word.
module noc_flit_unpacker #(
   parameter int         DATA_WIDTH = 32,
   parameter int         MAX_LEN    = 16,
   parameter logic [7:0] NODE_ID    = 8'd0
) (
   input  logic                  read_clk,
   input  logic                  read_reset,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_inc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_first,
   output logic                  out_last,
   output logic [7:0]            out_src,
   output logic                  pkt_done,
   output logic                  pkt_err,
   output logic [15:0]           drop_cnt
);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

`ifdef UNPACK_CHECKSUM_EN
   typedef enum logic [1:0] {HDR, PAY, DROP, CHK} state_t;
`else
   typedef enum logic [1:0] {HDR, PAY, DROP} state_t;
`endif

   state_t     state, state_nxt;
   logic [7:0] rem, rem_nxt;
   logic [7:0] src_q, src_nxt;
   logic       first_q, first_nxt;
   logic       pop, load, done_nxt, err_nxt;
   logic [7:0] hdr_dest, hdr_src, hdr_len;
`ifdef UNPACK_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] chk_acc, chk_acc_nxt;
   logic                  drop_pend, drop_pend_nxt;
`endif

   assign hdr_dest = fifo_data[31:24];
   assign hdr_src  = fifo_data[23:16];
   assign hdr_len  = fifo_data[15:8];
   assign fifo_inc = pop;

   always_comb begin
      pop = 1'b0;
      case (state)
         HDR, DROP: pop = !fifo_empty;
         PAY:       pop = !fifo_empty && (!out_valid || out_ready);
`ifdef UNPACK_CHECKSUM_EN
         CHK:       pop = !fifo_empty;
`endif
         default:   pop = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      src_nxt   = src_q;
      first_nxt = first_q;
      load      = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
`ifdef UNPACK_CHECKSUM_EN
      chk_acc_nxt   = chk_acc;
      drop_pend_nxt = drop_pend;
`endif
      if (pop) begin
         case (state)
            HDR: begin
               rem_nxt = hdr_len;
`ifdef UNPACK_CHECKSUM_EN
               chk_acc_nxt   = fifo_data;
               drop_pend_nxt = 1'b0;
`endif
               if (hdr_len == 8'd0) begin
`ifdef UNPACK_CHECKSUM_EN
                  // Even an empty packet carries a check word that must be skipped.
                  state_nxt     = CHK;
                  drop_pend_nxt = 1'b1;
`else
                  done_nxt = 1'b1;
                  err_nxt  = 1'b1;
`endif
               end else if (hdr_len > MAX_LEN_B || hdr_dest != NODE_ID) begin
                  state_nxt = DROP;
               end else begin
                  state_nxt = PAY;
                  src_nxt   = hdr_src;
                  first_nxt = 1'b1;
               end
            end
            PAY: begin
               load      = 1'b1;
               first_nxt = 1'b0;
               if (rem != 8'd0) rem_nxt = rem - 8'd1;
`ifdef UNPACK_CHECKSUM_EN
               chk_acc_nxt = chk_acc ^ fifo_data;
`endif
               if (rem == 8'd1) begin
`ifdef UNPACK_CHECKSUM_EN
                  state_nxt = CHK;
`else
                  state_nxt = HDR;
                  done_nxt  = 1'b1;
`endif
               end
            end
            DROP: begin
               if (rem != 8'd0) rem_nxt = rem - 8'd1;
               if (rem == 8'd1) begin
`ifdef UNPACK_CHECKSUM_EN
                  state_nxt     = CHK;
                  drop_pend_nxt = 1'b1;
`else
                  state_nxt = HDR;
                  done_nxt  = 1'b1;
                  err_nxt   = 1'b1;
`endif
               end
            end
`ifdef UNPACK_CHECKSUM_EN
            CHK: begin
               state_nxt = HDR;
               done_nxt  = 1'b1;
               err_nxt   = drop_pend || (fifo_data != chk_acc);
            end
`endif
            default: state_nxt = HDR;
         endcase
      end
   end

   always_ff @(posedge read_clk) begin
      if (read_reset) begin
         state     <= HDR;
         rem       <= 8'd0;
         src_q     <= 8'd0;
         first_q   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         out_src   <= 8'd0;
         pkt_done  <= 1'b0;
         pkt_err   <= 1'b0;
         drop_cnt  <= 16'd0;
`ifdef UNPACK_CHECKSUM_EN
         chk_acc   <= '0;
         drop_pend <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         rem      <= rem_nxt;
         src_q    <= src_nxt;
         first_q  <= first_nxt;
         pkt_done <= done_nxt;
         pkt_err  <= err_nxt;
`ifdef UNPACK_CHECKSUM_EN
         chk_acc   <= chk_acc_nxt;
         drop_pend <= drop_pend_nxt;
`endif
         if (done_nxt && err_nxt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         // src travels with each word so a next-header pop cannot disturb a stalled word.
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= fifo_data;
            out_first <= first_q;
            out_last  <= (rem == 8'd1);
            out_src   <= src_q;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_noc_flit_unpacker.sv
// Directed bench for noc_flit_unpacker: packet-level model feeding expected-word and expected-completion queues.
`timescale 1ns/1ps
module tb_noc_flit_unpacker;
   localparam int         MAX_LEN = 16;
   localparam logic [7:0] NODE_ID = 8'd0;

   typedef struct packed { logic [31:0] d; logic f; logic l; logic [7:0] s; } wexp_t;
   typedef struct packed { logic err; logic [15:0] cnt; } dexp_t;

   logic        clk = 1'b0;
   logic        read_reset = 1'b1;
   logic [31:0] fifo_data = 32'h0;
   logic        fifo_empty = 1'b1;
   logic        fifo_inc;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_first, out_last;
   logic [7:0]  out_src;
   logic        pkt_done, pkt_err;
   logic [15:0] drop_cnt;

   noc_flit_unpacker #(.DATA_WIDTH(32), .MAX_LEN(MAX_LEN), .NODE_ID(NODE_ID)) dut (
      .read_clk(clk), .read_reset(read_reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_inc(fifo_inc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_first(out_first), .out_last(out_last), .out_src(out_src), .pkt_done(pkt_done),
      .pkt_err(pkt_err), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [31:0] fq[$];
   wexp_t       exp_w[$];
   dexp_t       exp_d[$];
   logic [31:0] pl[0:63];
   int          exp_drops = 0, acc_cnt = 0, done_cnt = 0, pop_cnt = 0, cyc = 0;
   logic        last_err = 1'b0;
   logic [7:0]  last_src = 8'h0;
   logic        inc_s = 1'b0;
   bit          rdy_mode = 1'b0;
   bit          chk_zero = 1'b0;

   task automatic refresh();
      fifo_empty = (fq.size() == 0);
      if (fq.size() == 0) fifo_data = 32'h0;
      else fifo_data = fq[0];
   endtask

   // One cycle: sample the pop strobe mid-cycle, apply it just after the edge.
   task automatic tick();
      @(negedge clk);
      inc_s = fifo_inc;
      @(posedge clk);
      #1;
      cyc++;
      if (inc_s && fq.size() != 0) begin
         void'(fq.pop_front());
         pop_cnt++;
      end
      refresh();
      if (rdy_mode) out_ready = (cyc % 3 != 1);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pushes header + n words of pl[] and records what the packet rules say must come out.
   task automatic send(input logic [31:0] hdr, input int n);
      logic [7:0]  dest, src, len;
      logic [31:0] x;
      logic        drop, bad_chk;
      dest = hdr[31:24];
      src  = hdr[23:16];
      len  = hdr[15:8];
      x    = hdr;
      fq.push_back(hdr);
      for (int i = 0; i < n; i++) begin
         fq.push_back(pl[i]);
         x = x ^ pl[i];
      end
      drop    = (len == 8'd0) || (int'(len) > MAX_LEN) || (dest != NODE_ID);
      bad_chk = 1'b0;
`ifdef UNPACK_CHECKSUM_EN
      fq.push_back(chk_zero ? 32'h0 : x);
      bad_chk = chk_zero && (x != 32'h0);
`endif
      if (drop) begin
         exp_drops++;
         exp_d.push_back({1'b1, 16'(exp_drops)});
      end else begin
         for (int i = 0; i < int'(len); i++)
            exp_w.push_back({pl[i], (i == 0), (i == int'(len) - 1), src});
         if (bad_chk) begin
            exp_drops++;
            exp_d.push_back({1'b1, 16'(exp_drops)});
         end else begin
            exp_d.push_back({1'b0, 16'(exp_drops)});
         end
      end
      refresh();
   endtask

   task automatic clear_model();
      exp_w.delete();
      exp_d.delete();
      exp_drops = 0;
      acc_cnt   = 0;
      done_cnt  = 0;
      pop_cnt   = 0;
      last_err  = 1'b0;
      last_src  = 8'h0;
   endtask

   task automatic do_reset();
      read_reset = 1'b1;
      out_ready  = 1'b0;
      rdy_mode   = 1'b0;
      chk_zero   = 1'b0;
      fq.delete();
      refresh();
      tick();
      tick();
      clear_model();
      read_reset = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((fq.size() != 0 || exp_w.size() != 0 || exp_d.size() != 0 || out_valid) && k < 3000) begin
         tick();
         k++;
      end
      chk("drain_in_budget", 64'(k < 3000), 64'd1);
      repeat (3) tick();
   endtask

   // Compare process: every accepted word, every completion, stall stability, pop legality.
   logic  prev_stall = 1'b0;
   wexp_t pw;
   always @(negedge clk) begin
      wexp_t w;
      dexp_t d;
      if (read_reset) begin
         prev_stall = 1'b0;
      end else begin
         if (fifo_inc && fifo_empty) begin
            bad++;
            $display("FAIL pop_when_empty: fifo_inc=1 with fifo_empty=1");
         end
         if (prev_stall) begin
            total++;
            if (!out_valid || {out_data, out_first, out_last, out_src} !== pw) begin
               bad++;
               $display("FAIL stall_stable: got v=%0b %0h expected v=1 %0h", out_valid,
                        {out_data, out_first, out_last, out_src}, pw);
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (exp_w.size() == 0) begin
               bad++;
               $display("FAIL unexpected_word: got %0h expected none", out_data);
            end else begin
               w = exp_w.pop_front();
               if ({out_data, out_first, out_last, out_src} !== w) begin
                  bad++;
                  $display("FAIL word: got %0h expected %0h", {out_data, out_first, out_last, out_src}, w);
               end
            end
            acc_cnt++;
            last_src = out_src;
         end
         if (pkt_done) begin
            total++;
            done_cnt++;
            last_err = pkt_err;
            if (exp_d.size() == 0) begin
               bad++;
               $display("FAIL unexpected_done: got err=%0b expected none", pkt_err);
            end else begin
               d = exp_d.pop_front();
               if ({pkt_err, drop_cnt} !== d) begin
                  bad++;
                  $display("FAIL done: got err/cnt %0h expected %0h", {pkt_err, drop_cnt}, d);
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         pw = {out_data, out_first, out_last, out_src};
      end
   end

   initial begin
      refresh();
      tick();
      tick();
      chk("rst_flags", {out_valid, out_first, out_last, pkt_done, pkt_err, fifo_inc}, 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_src", out_src, 64'd0);
      chk("rst_drop", drop_cnt, 64'd0);

      // Basic two-word packet.
      do_reset();
      out_ready = 1'b1;
      pl[0] = 32'h12345678;
      pl[1] = 32'h87654321;
      send(32'h00050200, 2);
      wait_idle();
      chk("t1_words", acc_cnt, 64'd2);
      chk("t1_src", last_src, 64'h05);
      chk("t1_done", done_cnt, 64'd1);
      chk("t1_err", last_err, 64'd0);

      // Same packet with the consumer stalled.
      do_reset();
      send(32'h00050200, 2);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t2_valid", out_valid, 64'd1);
         chk("t2_data", out_data, 64'h12345678);
         chk("t2_noinc", fifo_inc, 64'd0);
         tick();
      end
      out_ready = 1'b1;
      wait_idle();
      chk("t2_words", acc_cnt, 64'd2);

      // Misaddressed packet.
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) pl[i] = 32'hBEEF0000 + i;
      send(32'h07010300, 3);
      wait_idle();
      chk("t3_pops", pop_cnt, 64'd4);
      chk("t3_words", acc_cnt, 64'd0);
      chk("t3_err", last_err, 64'd1);
      chk("t3_drop", drop_cnt, 64'd1);

      // Zero length, oversize length, then a good packet under bursty ready.
      do_reset();
      rdy_mode = 1'b1;
      send(32'h00010000, 0);
      for (int i = 0; i < 32; i++) pl[i] = 32'hD0000000 + i;
      send(32'h00012000, 32);
      pl[0] = 32'hA0A0A0A0;
      pl[1] = 32'hB1B1B1B1;
      pl[2] = 32'hC2C2C2C2;
      send(32'h00020300, 3);
      wait_idle();
      chk("t4_drop", drop_cnt, 64'd2);
      chk("t4_words", acc_cnt, 64'd3);
      chk("t4_src", last_src, 64'h02);

      // MAX_LEN accepted, MAX_LEN+1 dropped, back to back.
      do_reset();
      rdy_mode = 1'b1;
      for (int i = 0; i < 17; i++) pl[i] = 32'h01010101 * (i + 1);
      send(32'h00041000, 16);
      send(32'h00041100, 17);
      pl[0] = 32'h5A5A5A5A;
      send(32'h00060100, 1);
      wait_idle();
      chk("t5_words", acc_cnt, 64'd17);
      chk("t5_drop", drop_cnt, 64'd1);
      chk("t5_src", last_src, 64'h06);

      // Reset with a packet half received.
      do_reset();
      pl[0] = 32'h11111111;
      send(32'h00090400, 1);
      tick();
      tick();
      tick();
      chk("t6_mid_valid", out_valid, 64'd1);
      read_reset = 1'b1;
      tick();
      chk("t6_rst_flags", {out_valid, out_first, out_last, pkt_done, pkt_err}, 64'd0);
      chk("t6_rst_data", out_data, 64'd0);
      chk("t6_rst_src", out_src, 64'd0);
      fq.delete();
      refresh();
      clear_model();
      read_reset = 1'b0;
      out_ready  = 1'b1;
      pl[0] = 32'hCAFEF00D;
      send(32'h00030100, 1);
      wait_idle();
      chk("t6_words", acc_cnt, 64'd1);
      chk("t6_src", last_src, 64'h03);
      chk("t6_err", last_err, 64'd0);
      chk("t6_drop", drop_cnt, 64'd0);

`ifdef UNPACK_CHECKSUM_EN
      do_reset();
      out_ready = 1'b1;
      pl[0] = 32'hAAAAAAAA;
      send(32'h00000100, 1);
      wait_idle();
      chk("t7_good_err", last_err, 64'd0);
      chk("t7_good_drop", drop_cnt, 64'd0);
      chk_zero = 1'b1;
      send(32'h00000100, 1);
      wait_idle();
      chk("t7_bad_err", last_err, 64'd1);
      chk("t7_bad_drop", drop_cnt, 64'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
